ofdm_symbol_scheduler: RTL
==========================

Name: ofdm_symbol_scheduler

Overview:
- Sits between the modulation stage and the pilot insertion stage of the OFDM transmitter.
- Shares that single datapath between two requesters: the SIGNAL-field source (one BPSK symbol) and the DATA source (N symbols).
- Cuts the combined stream into 48-sample OFDM symbols, zero-pads a short last DATA symbol, and tags every beat with symbol-last/frame-last flags and the pilot polarity index (0..126).

Parameters:
- DATA_W, 32, I/Q sample width ({Q[15:0], I[15:0]}).
- DATA_PER_SYM, 48, data subcarriers per OFDM symbol.
- PILOT_SEQ_LEN, 127, pilot polarity sequence length; pilot_idx wraps modulo this value.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- s_sig_tvalid  in  1  SIGNAL source valid
- s_sig_tready  out  1  SIGNAL source ready
- s_sig_tdata  in  DATA_W  SIGNAL sample
- s_sig_tlast  in  1  SIGNAL source end marker (checked only)
- s_dat_tvalid  in  1  DATA source valid
- s_dat_tready  out  1  DATA source ready
- s_dat_tdata  in  DATA_W  DATA sample
- s_dat_tlast  in  1  last DATA sample of frame
- m_axis_tvalid  out  1  to pilot inserter
- m_axis_tready  in  1  from pilot inserter
- m_axis_tdata  out  DATA_W  sample (zero during padding)
- m_axis_tlast  out  1  last beat of frame
- m_axis_symb_tlast  out  1  last beat (index 47) of each OFDM symbol
- m_pilot_idx  out  7  pilot polarity index of the current symbol
- sym_count  out  16  DATA symbols emitted in the current/last frame
- frame_done  out  1  one-cycle pulse when a frame's final beat handshakes
- sig_len_err  out  1  one-cycle pulse on SIGNAL length mismatch

Behaviour:
- Reset: all outputs 0; state IDLE; beat_cnt=0; pilot_idx=0; sym_count=0.
- Output register stage, latency 1 cycle. Register loads when m_axis_tready || !m_axis_tvalid (load_en).
- Selected source: s_x_tready = load_en && state selects x. Unselected source tready=0. Neither source tready is ever high in IDLE or PAD.
- FSM states:
  - IDLE: wait for s_sig_tvalid, then go to SIG with beat_cnt=0, pilot_idx=0.
  - SIG: pass SIGNAL beats.
    - At beat_cnt==47, emit symb_tlast=1 and go to DATA; pilot_idx becomes 1.
    - sig_len_err pulses if s_sig_tlast==1 on a beat other than 47, or ==0 on beat 47. Length is always forced to 48.
  - DATA: pass DATA beats; beat_cnt increments on each accepted beat.
    - beat 47 without tlast: symb_tlast=1, beat_cnt=0, sym_count+1, pilot_idx=(pilot_idx+1) mod 127.
    - beat 47 with tlast: symb_tlast=1 and tlast=1; go to IDLE.
    - tlast on beat k<47: emit beat k with symb_tlast=0, tlast=0; go to PAD.
  - PAD: emit zero beats k+1..47. The beat at 47 carries symb_tlast=1 and tlast=1; then go to IDLE.
- sym_count counts the padded symbol once. It holds after the frame and clears on the next IDLE->SIG transition.
- frame_done pulses in the cycle the tlast beat handshakes on m_axis.
- m_pilot_idx is registered with each beat and is constant across all 48 beats of a symbol. Wrap is 126->0.
- Backpressure: while m_axis_tvalid && !m_axis_tready, all output fields hold and no source is accepted. PAD beats also stall.
- If s_dat_tvalid is low in DATA, the output goes idle (tvalid drops after the pending beat is accepted). The symbol is not padded; the block waits.
- Simultaneous: s_sig_tvalid during DATA/PAD is ignored until IDLE.
- Reset mid-frame: the frame is abandoned and no tlast is emitted. Downstream must also be reset.

Decomposition:
- Package ofdm_tx_pkg holds:
  - constants N_DATA_SC=48, PILOT_SEQ_LEN=127, SAMPLE_W=32;
  - enum sched_state_t {IDLE, SIG, DATA, PAD}.
- One sub-module, ofdm_sched_outreg: load-enabled output register for tdata/tlast/symb_tlast/pilot_idx/tvalid. The FSM stays in the top.

Test Plan:
- 48 SIGNAL + 96 DATA beats, tlast on 96th, m_tready=1.
  - 144 out beats; symb_tlast at beats 48/96/144; tlast at 144.
  - pilot_idx 0,1,2 per symbol; sym_count=2; one frame_done.
- 48 SIGNAL + 50 DATA beats.
  - 46 zero pad beats; 144 total beats; tlast at 144; sym_count=2.
- SIGNAL tlast on beat 40 → sig_len_err pulse; SIGNAL symbol still 48 beats.
- DATA of 127*48 beats → pilot_idx runs 1..126 then 0 on the last symbol; sym_count=127.
- Random m_tready (50%) plus random source gaps → output identical to the no-stall run; no beat dropped or duplicated; fields stable while stalled.
- rst asserted at beat 70 → next cycle all outputs 0; new frame then starts cleanly with pilot_idx=0.

Source files
------------

// File: rtl/ofdm_tx_pkg.sv
// Shared types and constants for the OFDM transmitter symbol path.
package ofdm_tx_pkg;

  localparam int unsigned N_DATA_SC     = 48;
  localparam int unsigned PILOT_SEQ_LEN = 127;
  localparam int unsigned SAMPLE_W      = 32;
  localparam int unsigned PILOT_IDX_W   = 7;
  localparam int unsigned SYM_CNT_W     = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SIG  = 2'd1,
    DATA = 2'd2,
    PAD  = 2'd3
  } sched_state_t;

  // One output beat toward the pilot inserter.
  typedef struct packed {
    logic [SAMPLE_W-1:0]    tdata;
    logic                   tlast;
    logic                   symb_tlast;
    logic [PILOT_IDX_W-1:0] pilot_idx;
  } sched_beat_t;

endpackage

// File: rtl/ofdm_sched_outreg.sv
// Load-enabled output register stage for the symbol scheduler.
module ofdm_sched_outreg
  import ofdm_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_en,
  input  logic        in_valid,
  input  sched_beat_t in_beat,
  output logic        out_valid,
  output sched_beat_t out_beat
);

  // Valid follows every load; payload only updates with a real beat so it holds while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_beat  <= '0;
    end else if (load_en) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_beat <= in_beat;
      end
    end
  end

endmodule

// File: rtl/ofdm_symbol_scheduler.sv
// Arbitrates SIGNAL and DATA sources into 48-sample OFDM symbols with pad and pilot tagging.
module ofdm_symbol_scheduler
  import ofdm_tx_pkg::*;
#(
  parameter int unsigned DATA_W        = SAMPLE_W,
  parameter int unsigned DATA_PER_SYM  = N_DATA_SC,
  parameter int unsigned PILOT_SEQ_LEN = ofdm_tx_pkg::PILOT_SEQ_LEN
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_sig_tvalid,
  output logic                   s_sig_tready,
  input  logic [DATA_W-1:0]      s_sig_tdata,
  input  logic                   s_sig_tlast,
  input  logic                   s_dat_tvalid,
  output logic                   s_dat_tready,
  input  logic [DATA_W-1:0]      s_dat_tdata,
  input  logic                   s_dat_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [DATA_W-1:0]      m_axis_tdata,
  output logic                   m_axis_tlast,
  output logic                   m_axis_symb_tlast,
  output logic [PILOT_IDX_W-1:0] m_pilot_idx,
  output logic [SYM_CNT_W-1:0]   sym_count,
  output logic                   frame_done,
  output logic                   sig_len_err
);

  localparam int unsigned BEAT_W = $clog2(DATA_PER_SYM);
  localparam logic [BEAT_W-1:0]      LAST_BEAT  = BEAT_W'(DATA_PER_SYM - 1);
  localparam logic [PILOT_IDX_W-1:0] LAST_PILOT = PILOT_IDX_W'(PILOT_SEQ_LEN - 1);

  sched_state_t           state_q, state_d;
  logic [BEAT_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic [PILOT_IDX_W-1:0] pilot_q, pilot_d;
  logic [SYM_CNT_W-1:0]   sym_count_d;
  logic                   sig_len_err_d;
  logic                   load_en_c;
  logic                   last_beat_c;
  logic                   in_valid;
  sched_beat_t            in_beat;
  logic                   out_valid;
  sched_beat_t            out_beat;

  assign load_en_c   = m_axis_tready | ~out_valid;
  assign last_beat_c = (beat_cnt_q == LAST_BEAT);

  // State, counters and the error pulse register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      pilot_q     <= '0;
      sym_count   <= '0;
      sig_len_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      pilot_q     <= pilot_d;
      sym_count   <= sym_count_d;
      sig_len_err <= sig_len_err_d;
    end
  end

  // Next-state, source handshakes and the beat offered to the output register.
  always_comb begin
    state_d       = state_q;
    beat_cnt_d    = beat_cnt_q;
    pilot_d       = pilot_q;
    sym_count_d   = sym_count;
    sig_len_err_d = 1'b0;
    s_sig_tready  = 1'b0;
    s_dat_tready  = 1'b0;
    in_valid      = 1'b0;
    in_beat       = '0;
    in_beat.pilot_idx = pilot_q;

    unique case (state_q)
      IDLE: begin
        if (s_sig_tvalid) begin
          state_d     = SIG;
          beat_cnt_d  = '0;
          pilot_d     = '0;
          sym_count_d = '0;
        end
      end

      SIG: begin
        s_sig_tready = load_en_c;
        if (s_sig_tvalid && load_en_c) begin
          in_valid           = 1'b1;
          in_beat.tdata      = SAMPLE_W'(s_sig_tdata);
          in_beat.symb_tlast = last_beat_c;
          // The SIGNAL symbol is always cut at 48 beats; a misplaced tlast is only flagged.
          sig_len_err_d      = (s_sig_tlast != last_beat_c);
          if (last_beat_c) begin
            beat_cnt_d = '0;
            pilot_d    = PILOT_IDX_W'(1);
            state_d    = DATA;
          end else begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          end
        end
      end

      DATA: begin
        s_dat_tready = load_en_c;
        if (s_dat_tvalid && load_en_c) begin
          in_valid           = 1'b1;
          in_beat.tdata      = SAMPLE_W'(s_dat_tdata);
          in_beat.symb_tlast = last_beat_c;
          in_beat.tlast      = last_beat_c & s_dat_tlast;
          if (last_beat_c) begin
            beat_cnt_d  = '0;
            sym_count_d = sym_count + SYM_CNT_W'(1);
            if (s_dat_tlast) begin
              state_d = IDLE;
            end else begin
              pilot_d = (pilot_q == LAST_PILOT) ? '0 : pilot_q + PILOT_IDX_W'(1);
            end
          end else begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
            if (s_dat_tlast) begin
              state_d = PAD;
            end
          end
        end
      end

      PAD: begin
        if (load_en_c) begin
          in_valid           = 1'b1;
          in_beat.symb_tlast = last_beat_c;
          in_beat.tlast      = last_beat_c;
          if (last_beat_c) begin
            beat_cnt_d  = '0;
            sym_count_d = sym_count + SYM_CNT_W'(1);
            state_d     = IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  ofdm_sched_outreg u_outreg (
    .clk       (clk),
    .rst       (rst),
    .load_en   (load_en_c),
    .in_valid  (in_valid),
    .in_beat   (in_beat),
    .out_valid (out_valid),
    .out_beat  (out_beat)
  );

  assign m_axis_tvalid     = out_valid;
  assign m_axis_tdata      = DATA_W'(out_beat.tdata);
  assign m_axis_tlast      = out_beat.tlast;
  assign m_axis_symb_tlast = out_beat.symb_tlast;
  assign m_pilot_idx       = out_beat.pilot_idx;

  // Frame completion is the handshake of the tlast beat itself.
  assign frame_done = out_valid & m_axis_tready & out_beat.tlast;

endmodule
